// File: rtl/alu_mc_if.sv
// Operand/result handshake bundle for alu_mc: operands flow in on in_valid/in_ready,
// results flow out on out_valid/out_ready.
interface alu_mc_if #(
    parameter int DATA_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] opp_a;
    logic [DATA_W-1:0] opp_b;
    logic [3:0]        op;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] eval;
    logic              zero;
    logic              illegal;

    modport master (
        output in_valid, opp_a, opp_b, op, out_ready,
        input  in_ready, out_valid, eval, zero, illegal
    );

    modport slave (
        input  in_valid, opp_a, opp_b, op, out_ready,
        output in_ready, out_valid, eval, zero, illegal
    );
endinterface

// File: rtl/alu_mc.sv
// Multi-cycle execute-stage ALU: registered single-cycle ops plus iterative MUL/DIV.
// Define ALU_MC_MULDIV_EN to build the multiply/divide datapath; otherwise ops 10-15 flag illegal.
module alu_mc #(
    parameter int DATA_W = 32
) (
    input  logic    clk,
    input  logic    rst_n,
    alu_mc_if.slave bus
);
    localparam int SHAMT_W = $clog2(DATA_W);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t             state, state_n;
    logic [DATA_W-1:0]  eval_q, eval_n;
    logic               zero_q, zero_n;
    logic               illegal_q, illegal_n;
    logic               accept;
    logic               is_iter;
    logic               illegal_op;
    logic [DATA_W-1:0]  alu_res;
    logic [SHAMT_W-1:0] shamt;

    assign bus.in_ready  = (state == IDLE) || (state == DONE && bus.out_ready);
    assign bus.out_valid = (state == DONE);
    assign bus.eval      = eval_q;
    assign bus.zero      = zero_q;
    assign bus.illegal   = illegal_q;
    assign accept        = bus.in_valid && bus.in_ready;
    assign shamt         = bus.opp_b[SHAMT_W-1:0];

    always_comb begin
        alu_res = '0;
        case (bus.op)
            4'd0:    alu_res = bus.opp_a + bus.opp_b;
            4'd1:    alu_res = bus.opp_a - bus.opp_b;
            4'd2:    alu_res = bus.opp_a & bus.opp_b;
            4'd3:    alu_res = bus.opp_a | bus.opp_b;
            4'd4:    alu_res = bus.opp_a ^ bus.opp_b;
            4'd5:    alu_res = {{(DATA_W-1){1'b0}}, $signed(bus.opp_a) < $signed(bus.opp_b)};
            4'd6:    alu_res = {{(DATA_W-1){1'b0}}, bus.opp_a < bus.opp_b};
            4'd7:    alu_res = bus.opp_a << shamt;
            4'd8:    alu_res = bus.opp_a >> shamt;
            4'd9:    alu_res = $unsigned($signed(bus.opp_a) >>> shamt);
            default: alu_res = '0;
        endcase
    end

`ifdef ALU_MC_MULDIV_EN
    localparam logic [SHAMT_W-1:0] LAST = SHAMT_W'(DATA_W - 1);

    logic [DATA_W-1:0]  acc_hi, acc_lo, opnd;
    logic [DATA_W-1:0]  hi_n, lo_n, fin_raw, fin_res;
    logic [DATA_W-1:0]  a_mag, b_mag;
    logic [DATA_W:0]    sum, shifted, diff;
    logic [3:0]         op_q;
    logic [SHAMT_W-1:0] cnt;
    logic               res_neg, ge, div_signed, a_neg, b_neg, last;

    assign is_iter    = bus.op >= 4'd10;
    assign illegal_op = 1'b0;
    assign div_signed = (bus.op[3:2] == 2'b11) && !bus.op[0];
    assign a_neg      = div_signed && bus.opp_a[DATA_W-1];
    assign b_neg      = div_signed && bus.opp_b[DATA_W-1];
    assign a_mag      = a_neg ? -bus.opp_a : bus.opp_a;
    assign b_mag      = b_neg ? -bus.opp_b : bus.opp_b;
    assign last       = (cnt == LAST);

    // One shift-add (mul) or restoring-subtract (div) step; acc_lo holds multiplier or quotient bits.
    always_comb begin
        sum     = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : {(DATA_W+1){1'b0}});
        shifted = {acc_hi, acc_lo[DATA_W-1]};
        diff    = shifted - {1'b0, opnd};
        ge      = shifted >= {1'b0, opnd};
        hi_n    = sum[DATA_W:1];
        lo_n    = {sum[0], acc_lo[DATA_W-1:1]};
        if (op_q[3:2] == 2'b11) begin
            hi_n = ge ? diff[DATA_W-1:0] : shifted[DATA_W-1:0];
            lo_n = {acc_lo[DATA_W-2:0], ge};
        end
        case (op_q)
            4'd10, 4'd12, 4'd13: fin_raw = lo_n;
            default:             fin_raw = hi_n;
        endcase
        fin_res = res_neg ? -fin_raw : fin_raw;
    end

    // A zero divisor never sets the quotient sign, so signed DIV by zero still yields all ones.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_hi  <= '0;
            acc_lo  <= '0;
            opnd    <= '0;
            op_q    <= '0;
            cnt     <= '0;
            res_neg <= 1'b0;
        end else if (accept && is_iter) begin
            op_q   <= bus.op;
            cnt    <= '0;
            acc_hi <= '0;
            if (bus.op[3:2] == 2'b11) begin
                acc_lo  <= a_mag;
                opnd    <= b_mag;
                res_neg <= bus.op[1] ? a_neg : ((a_neg ^ b_neg) && (bus.opp_b != '0));
            end else begin
                acc_lo  <= bus.opp_b;
                opnd    <= bus.opp_a;
                res_neg <= 1'b0;
            end
        end else if (state == BUSY) begin
            acc_hi <= hi_n;
            acc_lo <= lo_n;
            cnt    <= cnt + {{(SHAMT_W-1){1'b0}}, 1'b1};
        end
    end
`else
    assign is_iter    = 1'b0;
    assign illegal_op = bus.op >= 4'd10;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            eval_q    <= '0;
            zero_q    <= 1'b1;
            illegal_q <= 1'b0;
        end else begin
            state     <= state_n;
            eval_q    <= eval_n;
            zero_q    <= zero_n;
            illegal_q <= illegal_n;
        end
    end

    always_comb begin
        state_n   = state;
        eval_n    = eval_q;
        zero_n    = zero_q;
        illegal_n = illegal_q;
        case (state)
            IDLE, DONE: begin
                if (accept) begin
                    if (is_iter) begin
                        state_n = BUSY;
                    end else begin
                        state_n   = DONE;
                        eval_n    = alu_res;
                        zero_n    = (alu_res == '0);
                        illegal_n = illegal_op;
                    end
                end else if (state == DONE && bus.out_ready) begin
                    state_n = IDLE;
                end
            end
            BUSY: begin
`ifdef ALU_MC_MULDIV_EN
                // The final iteration and sign correction share the last busy cycle.
                if (last) begin
                    state_n   = DONE;
                    eval_n    = fin_res;
                    zero_n    = (fin_res == '0);
                    illegal_n = 1'b0;
                end
`else
                state_n = IDLE;
`endif
            end
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_alu_mc.sv
// Directed, table-driven bench for alu_mc; expectations follow whichever build
// (ALU_MC_MULDIV_EN defined or not) is being compiled.
module tb_alu_mc;
    localparam int W = 32;

    typedef struct packed {
        logic [3:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp_eval;
        logic         exp_ill;
    } vec_t;

    logic clk;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;
    int   n;
    vec_t vecs[$];

    alu_mc_if #(.DATA_W(W)) bus ();

    alu_mc #(.DATA_W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic vec_t mk(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic [W-1:0] exp_eval, input logic exp_ill);
        vec_t v;
        v.op       = op;
        v.a        = a;
        v.b        = b;
        v.exp_eval = exp_eval;
        v.exp_ill  = exp_ill;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic checkResult(input string name, input logic [W-1:0] exp_eval, input logic exp_ill);
        checkOutput({name, " out_valid"}, W'(bus.out_valid), W'(1));
        checkOutput({name, " eval"}, bus.eval, exp_eval);
        checkOutput({name, " zero"}, W'(bus.zero), W'(exp_eval == '0));
        checkOutput({name, " illegal"}, W'(bus.illegal), W'(exp_ill));
    endtask

    task automatic applyStimulus(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        bus.in_valid = 1'b1;
        bus.op       = op;
        bus.opp_a    = a;
        bus.opp_b    = b;
    endtask

    task automatic waitResult();
        n = 1;
        while (!bus.out_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic runIter(input string name, input logic [3:0] op, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic [W-1:0] exp_eval);
        applyStimulus(op, a, b);
        @(negedge clk);
        bus.in_valid = 1'b0;
        checkOutput({name, " busy in_ready"}, W'(bus.in_ready), W'(0));
        waitResult();
        checkOutput({name, " latency"}, W'(n), W'(W + 1));
        checkResult(name, exp_eval, 1'b0);
    endtask

    initial begin
        vecs.push_back(mk(4'd0, 32'h0000_0005, 32'hFFFF_FFFB, 32'h0000_0000, 1'b0));
        vecs.push_back(mk(4'd9, 32'h8000_0000, 32'h0000_0004, 32'hF800_0000, 1'b0));
        vecs.push_back(mk(4'd5, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0));
        vecs.push_back(mk(4'd6, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0));
        vecs.push_back(mk(4'd1, 32'h0000_0003, 32'h0000_0005, 32'hFFFF_FFFE, 1'b0));
        vecs.push_back(mk(4'd2, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0));
        vecs.push_back(mk(4'd3, 32'hF0F0_F0F0, 32'h0F0F_0000, 32'hFFFF_F0F0, 1'b0));
        vecs.push_back(mk(4'd4, 32'hFFFF_0000, 32'hFF00_FF00, 32'h00FF_FF00, 1'b0));
        vecs.push_back(mk(4'd7, 32'h0000_0001, 32'h0000_0021, 32'h0000_0002, 1'b0));
        vecs.push_back(mk(4'd8, 32'h8000_0000, 32'h0000_001F, 32'h0000_0001, 1'b0));
        vecs.push_back(mk(4'd9, 32'h7FFF_FFFF, 32'h0000_0004, 32'h07FF_FFFF, 1'b0));
        vecs.push_back(mk(4'd5, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0));
        vecs.push_back(mk(4'd0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0));
`ifndef ALU_MC_MULDIV_EN
        vecs.push_back(mk(4'd10, 32'h0000_0003, 32'h0000_0004, 32'h0000_0000, 1'b1));
        vecs.push_back(mk(4'd0, 32'h0000_0002, 32'h0000_0003, 32'h0000_0005, 1'b0));
        vecs.push_back(mk(4'd13, 32'h0000_0007, 32'h0000_0000, 32'h0000_0000, 1'b1));
        vecs.push_back(mk(4'd15, 32'h0000_0007, 32'h0000_0000, 32'h0000_0000, 1'b1));
`endif

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.op        = '0;
        bus.opp_a     = '0;
        bus.opp_b     = '0;
        repeat (3) @(negedge clk);
        checkOutput("reset in_ready", W'(bus.in_ready), W'(1));
        checkOutput("reset out_valid", W'(bus.out_valid), W'(0));
        checkOutput("reset eval", bus.eval, '0);
        checkOutput("reset zero", W'(bus.zero), W'(1));
        checkOutput("reset illegal", W'(bus.illegal), W'(0));
        rst_n = 1'b1;
        @(negedge clk);

        // Back-to-back single-cycle ops: one result per cycle with in_ready held high.
        foreach (vecs[i]) begin
            applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b);
            @(negedge clk);
            checkResult($sformatf("vec%0d", i), vecs[i].exp_eval, vecs[i].exp_ill);
            checkOutput($sformatf("vec%0d in_ready", i), W'(bus.in_ready), W'(1));
        end
        bus.in_valid = 1'b0;
        @(negedge clk);
        checkOutput("drain out_valid", W'(bus.out_valid), W'(0));
        checkOutput("drain in_ready", W'(bus.in_ready), W'(1));

`ifdef ALU_MC_MULDIV_EN
        runIter("mul", 4'd10, 32'h0000_FFFF, 32'h0000_FFFF, 32'hFFFE_0001);
        runIter("mulhu", 4'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        runIter("div ovf", 4'd12, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        runIter("rem ovf", 4'd14, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000);
        runIter("rem neg", 4'd14, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF);
        runIter("div neg", 4'd12, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD);
        runIter("divu by0", 4'd13, 32'h0000_0007, 32'h0000_0000, 32'hFFFF_FFFF);
        runIter("remu by0", 4'd15, 32'h0000_0007, 32'h0000_0000, 32'h0000_0007);
        runIter("div neg by0", 4'd12, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFFF);
        runIter("rem neg by0", 4'd14, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9);

        // Stalled consumer: result must hold and a pending request must wait.
        bus.out_ready = 1'b0;
        applyStimulus(4'd13, 32'd100, 32'd7);
        @(negedge clk);
        applyStimulus(4'd0, 32'd2, 32'd3);
        waitResult();
        checkOutput("hold latency", W'(n), W'(W + 1));
        for (int k = 0; k < 5; k++) begin
            checkResult($sformatf("hold%0d", k), 32'd14, 1'b0);
            checkOutput($sformatf("hold%0d in_ready", k), W'(bus.in_ready), W'(0));
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        checkResult("release add", 32'd5, 1'b0);
        bus.in_valid = 1'b0;
        @(negedge clk);
        checkOutput("release drain", W'(bus.out_valid), W'(0));

        applyStimulus(4'd12, 32'd100, 32'd7);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (9) @(negedge clk);
`else
        bus.out_ready = 1'b0;
        applyStimulus(4'd0, 32'd7, 32'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        checkResult("pre-reset add", 32'd8, 1'b0);
        @(negedge clk);
        bus.out_ready = 1'b1;
`endif
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("midreset out_valid", W'(bus.out_valid), W'(0));
        checkOutput("midreset in_ready", W'(bus.in_ready), W'(1));
        checkOutput("midreset eval", bus.eval, '0);
        checkOutput("midreset zero", W'(bus.zero), W'(1));
        rst_n = 1'b1;
        applyStimulus(4'd0, 32'd2, 32'd3);
        @(negedge clk);
        checkResult("post-reset add", 32'd5, 1'b0);
        bus.in_valid = 1'b0;
        @(negedge clk);
        checkOutput("post-reset drain", W'(bus.out_valid), W'(0));
        repeat (W + 4) @(negedge clk);
        checkOutput("no stale result", W'(bus.out_valid), W'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
